// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE/RUN/PAUSE/FAIL/WIN state machine, frame-driven tick generator
// with manual and automatic speed control, saturating score and sticky end flags.
module game_sequencer #(
    parameter int SPEED_W      = 3,
    parameter int FRAMES_MAX   = 30,
    parameter int FRAMES_STEP  = 3,
    parameter int SCORE_W      = 8,
    parameter int AUTO_SPEEDUP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_restart,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_speed_up,
    input  logic               i_speed_down,
    input  logic               i_frame,
    input  logic               i_tick_done,
    input  logic               i_failure,
    input  logic               i_success,
    input  logic               i_eat,
    output logic               o_tick,
    output logic [2:0]         o_state,
    output logic [SPEED_W-1:0] o_speed,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_failure,
    output logic               o_success
);
    localparam int FRAME_W   = $clog2(FRAMES_MAX + 1);
    localparam int APPLE_W   = (AUTO_SPEEDUP > 1) ? $clog2(AUTO_SPEEDUP) : 1;
    localparam int SPEED_MAX = (2 ** SPEED_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_FAIL  = 3'd3,
        ST_WIN   = 3'd4
    } state_t;

    state_t               state;
    logic                 pause_q;
    logic [FRAME_W-1:0]   frame_cnt;
    logic [APPLE_W-1:0]   apple_cnt;
    logic                 pause_rise;
    logic                 eat_counted;
    logic                 auto_inc;
    logic                 tick_fire;
    logic [31:0]          step_total;
    logic [31:0]          period;
    logic [SPEED_W-1:0]   speed_next;
    int                   speed_sum;

    assign o_state = state;

    // Period is evaluated at 32 bits so fast speeds clamp to 1 instead of wrapping.
    always_comb begin
        pause_rise  = i_pause & ~pause_q;
        eat_counted = i_eat & ((state == ST_RUN) | o_tick);
        auto_inc    = eat_counted && (AUTO_SPEEDUP != 0) &&
                      ((32'(apple_cnt) + 32'd1) >= 32'(AUTO_SPEEDUP));
        step_total  = 32'(o_speed) * 32'(FRAMES_STEP);
        period      = ((step_total + 32'd1) >= 32'(FRAMES_MAX)) ? 32'd1
                                                                : 32'(FRAMES_MAX) - step_total;
        tick_fire   = 32'(frame_cnt) >= (period - 32'd1);
        speed_sum   = int'(o_speed) + int'(i_speed_up) + int'(auto_inc) - int'(i_speed_down);
        if (speed_sum < 0) begin
            speed_next = '0;
        end else if (speed_sum > SPEED_MAX) begin
            speed_next = '1;
        end else begin
            speed_next = SPEED_W'(speed_sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pause_q   <= 1'b0;
            frame_cnt <= '0;
            apple_cnt <= '0;
            o_tick    <= 1'b0;
            o_speed   <= '0;
            o_score   <= '0;
            o_failure <= 1'b0;
            o_success <= 1'b0;
        end else begin
            pause_q <= i_pause;
            if (i_restart) begin
                state     <= ST_IDLE;
                frame_cnt <= '0;
                apple_cnt <= '0;
                o_tick    <= 1'b0;
                o_score   <= '0;
                o_failure <= 1'b0;
                o_success <= 1'b0;
            end else begin
                o_speed <= speed_next;

                case (state)
                    ST_IDLE: if (i_start) state <= ST_RUN;
                    ST_RUN: begin
                        if (i_failure) begin
                            state     <= ST_FAIL;
                            o_failure <= 1'b1;
                        end else if (i_success) begin
                            state     <= ST_WIN;
                            o_success <= 1'b1;
                        end else if (pause_rise) begin
                            state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: if (pause_rise) state <= ST_RUN;
                    ST_FAIL:  state <= ST_FAIL;
                    ST_WIN:   state <= ST_WIN;
                    default:  state <= ST_IDLE;
                endcase

                // A raised tick survives state changes; only the core's done pulse drops it.
                if (o_tick) begin
                    if (i_tick_done) o_tick <= 1'b0;
                end else if ((state == ST_RUN) && i_frame) begin
                    if (tick_fire) begin
                        o_tick    <= 1'b1;
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + FRAME_W'(1);
                    end
                end

                if (eat_counted) begin
                    if (o_score != '1) o_score <= o_score + SCORE_W'(1);
                    apple_cnt <= auto_inc ? '0 : apple_cnt + APPLE_W'(1);
                end
            end
        end
    end
endmodule
